// File: rtl/sr_reg_bank.sv
// Clocked bank of SR storage elements with selectable S=R=1 resolution,
// per-channel change pulses, and sticky conflict tracking with a saturating count.
module sr_reg_bank #(
    parameter int unsigned             WIDTH   = 8,
    parameter int unsigned             MODE    = 0,
    parameter int unsigned             CNT_W   = 4,
    parameter logic [WIDTH-1:0]        RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RES_RESET  = 2'd0,
        RES_SET    = 2'd1,
        RES_HOLD   = 2'd2,
        RES_TOGGLE = 2'd3
    } res_mode_e;

    localparam res_mode_e RES = res_mode_e'(MODE[1:0]);

    if (MODE > 3) begin : g_bad_mode
        $error("sr_reg_bank: MODE must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sr_reg_bank: WIDTH must be 1..32");
    end
    if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt
        $error("sr_reg_bank: CNT_W must be 2..16");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] changed_q;
    logic [WIDTH-1:0] changed_d;
    logic [WIDTH-1:0] conflict_q;
    logic [WIDTH-1:0] conflict_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] both;
    logic [CNT_W-1:0] cnt_base;

    assign both = S & R;

    // Per-channel next state; a disabled bank simply holds.
    always_comb begin
        q_d = q_q;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                unique case ({S[i], R[i]})
                    2'b00: q_d[i] = q_q[i];
                    2'b10: q_d[i] = 1'b1;
                    2'b01: q_d[i] = 1'b0;
                    2'b11: begin
                        unique case (RES)
                            RES_RESET:  q_d[i] = 1'b0;
                            RES_SET:    q_d[i] = 1'b1;
                            RES_HOLD:   q_d[i] = q_q[i];
                            RES_TOGGLE: q_d[i] = ~q_q[i];
                            default:    q_d[i] = q_q[i];
                        endcase
                    end
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
    end

    assign changed_d = q_d ^ q_q;

    // Clear first, then fold in this edge's conflicts.
    always_comb begin
        conflict_d = clr_err ? '0 : conflict_q;
        cnt_base   = clr_err ? '0 : cnt_q;
        cnt_d      = cnt_base;
        if (en) begin
            conflict_d = conflict_d | both;
            if (|both && cnt_base != CNT_MAX) begin
                cnt_d = cnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= RST_VAL;
            changed_q  <= '0;
            conflict_q <= '0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            changed_q  <= changed_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Q            = q_q;
    assign Qb           = ~q_q;
    assign changed      = changed_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank: four instances, one per conflict mode,
// checked against a behavioural model through an expectation queue.
module tb_sr_reg_bank;

    localparam int W = 4;
    localparam int CW = 2;
    localparam logic [W-1:0] RV = 4'b1010;

    typedef struct {
        logic [W-1:0]  q;
        logic [W-1:0]  ch;
        logic [W-1:0]  cf;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic clr_err = 1'b0;
    logic [W-1:0] s = '0;
    logic [W-1:0] r = '0;

    logic [W-1:0]  q_o   [4];
    logic [W-1:0]  qb_o  [4];
    logic [W-1:0]  ch_o  [4];
    logic [W-1:0]  cf_o  [4];
    logic [CW-1:0] cnt_o [4];

    logic [W-1:0]  mq   [4];
    logic [W-1:0]  mcf  [4];
    logic [CW-1:0] mcnt [4];

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_reg_bank #(
            .WIDTH(W), .MODE(m), .CNT_W(CW), .RST_VAL(RV)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .S(s), .R(r),
            .clr_err(clr_err), .Q(q_o[m]), .Qb(qb_o[m]),
            .changed(ch_o[m]), .conflict(cf_o[m]),
            .conflict_cnt(cnt_o[m])
        );
    end

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            mq[m] = RV;
            mcf[m] = '0;
            mcnt[m] = '0;
            sb.push_back('{q: RV, ch: '0, cf: '0, cnt: '0});
        end
    endtask

    task automatic model_step();
        exp_t e;
        logic [W-1:0] nq;
        for (int m = 0; m < 4; m++) begin
            nq = mq[m];
            for (int b = 0; b < W; b++) begin
                if (en && s[b] && !r[b]) nq[b] = 1'b1;
                else if (en && r[b] && !s[b]) nq[b] = 1'b0;
                else if (en && s[b] && r[b]) begin
                    if (m == 0) nq[b] = 1'b0;
                    else if (m == 1) nq[b] = 1'b1;
                    else if (m == 3) nq[b] = ~mq[m][b];
                end
            end
            if (clr_err) begin
                mcf[m] = '0;
                mcnt[m] = '0;
            end
            if (en) begin
                mcf[m] = mcf[m] | (s & r);
                if ((s & r) != 0 && mcnt[m] != 2'd3) mcnt[m] = mcnt[m] + 2'd1;
            end
            e.q = nq;
            e.ch = nq ^ mq[m];
            e.cf = mcf[m];
            e.cnt = mcnt[m];
            mq[m] = nq;
            sb.push_back(e);
        end
    endtask

    task automatic check4(input string tag);
        exp_t e;
        for (int m = 0; m < 4; m++) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s: scoreboard empty", tag);
                return;
            end
            e = sb.pop_front();
            checks++;
            assert (q_o[m] === e.q) else begin
                errors++;
                $error("FAIL %s m%0d Q: got %b exp %b", tag, m, q_o[m], e.q);
            end
            checks++;
            assert (qb_o[m] === ~e.q) else begin
                errors++;
                $error("FAIL %s m%0d Qb: got %b exp %b", tag, m, qb_o[m], ~e.q);
            end
            checks++;
            assert (ch_o[m] === e.ch) else begin
                errors++;
                $error("FAIL %s m%0d changed: got %b exp %b", tag, m, ch_o[m], e.ch);
            end
            checks++;
            assert (cf_o[m] === e.cf) else begin
                errors++;
                $error("FAIL %s m%0d conflict: got %b exp %b", tag, m, cf_o[m], e.cf);
            end
            checks++;
            assert (cnt_o[m] === e.cnt) else begin
                errors++;
                $error("FAIL %s m%0d cnt: got %0d exp %0d", tag, m, cnt_o[m], e.cnt);
            end
        end
    endtask

    task automatic step(input logic e_i, input logic [W-1:0] s_i,
                        input logic [W-1:0] r_i, input logic c_i,
                        input string tag);
        @(negedge clk);
        en = e_i;
        s = s_i;
        r = r_i;
        clr_err = c_i;
        model_step();
        @(posedge clk);
        #1;
        check4(tag);
    endtask

    initial begin
        // Asynchronous reset before the first clock edge.
        #2 rst = 1'b1;
        model_reset();
        #1 check4("reset");
        #1 rst = 1'b0;

        step(1, 4'b0000, 4'b1111, 0, "clear_q");
        step(1, 4'b0011, 4'b0000, 0, "set");
        step(1, 4'b0000, 4'b0001, 0, "reset_bit");
        step(1, 4'b0000, 4'b0000, 0, "hold");

        // Load 0101 then a single all-channel conflict.
        step(1, 4'b0101, 4'b1010, 1, "load_0101");
        step(1, 4'b1111, 4'b1111, 0, "conflict_all");

        for (int k = 0; k < 5; k++)
            step(0, 4'b1111, 4'b1111, 0, "en_low");

        step(1, 4'b0000, 4'b0000, 1, "clr_idle");
        for (int k = 0; k < 5; k++)
            step(1, 4'b0001, 4'b0001, 0, "saturate");
        step(1, 4'b0100, 4'b0100, 1, "clr_with_conf");
        step(1, 4'b0000, 4'b0000, 1, "clr_no_conf");
        step(1, 4'b0010, 4'b0010, 0, "pre_clr_dis");
        step(0, 4'b1111, 4'b1111, 1, "clr_en_low");

        step(1, 4'b0001, 4'b0001, 0, "toggle_a");
        step(1, 4'b0001, 4'b0001, 0, "toggle_b");
        step(1, 4'b0001, 4'b0001, 0, "toggle_c");

        // Reset pulse between edges while toggling.
        #1 rst = 1'b1;
        sb.delete();
        model_reset();
        #1 check4("mid_reset");
        #1 rst = 1'b0;
        step(1, 4'b0001, 4'b0001, 0, "resume_a");
        step(1, 4'b0001, 4'b0001, 0, "resume_b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
